// File: rtl/r5_pkg.sv
// Shared types and constants for the radix-5 input path.
// Frames are five complex points; index 0 is the first sample accepted.
package r5_pkg;
    localparam int R5_POINTS = 5;
    localparam int R5_DW     = 32;
    localparam int R5_IDX_W  = $clog2(R5_POINTS);

    typedef struct packed {
        logic [R5_DW-1:0] re;
        logic [R5_DW-1:0] img;
    } cplx_t;

    typedef cplx_t [R5_POINTS-1:0] frame_t;
endpackage

// File: rtl/r5_frame_bank.sv
// Five-entry complex register bank: single indexed write, whole-frame load,
// parallel read. A whole-frame load takes precedence over the indexed write.
module r5_frame_bank
    import r5_pkg::*;
#(
    parameter int DW = R5_DW
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [R5_IDX_W-1:0]              wr_idx,
    input  logic [DW-1:0]                    wr_re,
    input  logic [DW-1:0]                    wr_img,
    input  logic                             ld_en,
    input  logic [R5_POINTS-1:0][DW-1:0]     ld_re,
    input  logic [R5_POINTS-1:0][DW-1:0]     ld_img,
    output logic [R5_POINTS-1:0][DW-1:0]     rd_re,
    output logic [R5_POINTS-1:0][DW-1:0]     rd_img
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_re  <= '0;
            rd_img <= '0;
        end else if (ld_en) begin
            rd_re  <= ld_re;
            rd_img <= ld_img;
        end else if (wr_en) begin
            rd_re[wr_idx]  <= wr_re;
            rd_img[wr_idx] <= wr_img;
        end
    end
endmodule

// File: rtl/r5_input_collector.sv
// Serial-to-parallel collector: groups accepted samples into 5-point frames,
// with one pending frame so collection can overlap a stalled output.
module r5_input_collector
    import r5_pkg::*;
#(
    parameter int DW = R5_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sof,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_img,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] a_re,
    output logic [DW-1:0] a_img,
    output logic [DW-1:0] b_re,
    output logic [DW-1:0] b_img,
    output logic [DW-1:0] c_re,
    output logic [DW-1:0] c_img,
    output logic [DW-1:0] d_re,
    output logic [DW-1:0] d_img,
    output logic [DW-1:0] e_re,
    output logic [DW-1:0] e_img,
    output logic          sof_err,
    output logic [15:0]   frame_cnt
);
    localparam logic [R5_IDX_W-1:0] LAST = R5_IDX_W'(R5_POINTS - 1);

    logic [R5_IDX_W-1:0] cnt;
    logic [R5_IDX_W-1:0] wr_idx;
    logic pend;
    logic accept, restart, complete, can_load, load;
    logic [R5_POINTS-1:0][DW-1:0] col_re, col_img, ld_re, ld_img, out_re, out_img;

    assign in_ready = !pend;
    assign accept   = in_valid && in_ready;
    assign restart  = accept && (in_sof || cnt == '0);
    assign complete = accept && !in_sof && cnt == LAST;
    assign wr_idx   = restart ? '0 : cnt;
    assign can_load = !out_valid || out_ready;
    assign load     = (complete || pend) && can_load;

    // Point 4 bypasses the collect bank when the frame completes straight into the output.
    always_comb begin
        ld_re  = col_re;
        ld_img = col_img;
        if (complete) begin
            ld_re[R5_POINTS-1]  = in_re;
            ld_img[R5_POINTS-1] = in_img;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            pend      <= 1'b0;
            out_valid <= 1'b0;
            sof_err   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            sof_err <= accept && in_sof && cnt != '0;
            if (accept)
                cnt <= restart ? R5_IDX_W'(1) : (complete ? '0 : cnt + R5_IDX_W'(1));
            if (load)
                pend <= 1'b0;
            else if (complete)
                pend <= 1'b1;
            if (load)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
            if (load)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    r5_frame_bank #(.DW(DW)) u_collect (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (accept),
        .wr_idx (wr_idx),
        .wr_re  (in_re),
        .wr_img (in_img),
        .ld_en  (1'b0),
        .ld_re  ('0),
        .ld_img ('0),
        .rd_re  (col_re),
        .rd_img (col_img)
    );

    r5_frame_bank #(.DW(DW)) u_output (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (1'b0),
        .wr_idx ('0),
        .wr_re  ('0),
        .wr_img ('0),
        .ld_en  (load),
        .ld_re  (ld_re),
        .ld_img (ld_img),
        .rd_re  (out_re),
        .rd_img (out_img)
    );

    assign a_re  = out_re[0];
    assign a_img = out_img[0];
    assign b_re  = out_re[1];
    assign b_img = out_img[1];
    assign c_re  = out_re[2];
    assign c_img = out_img[2];
    assign d_re  = out_re[3];
    assign d_img = out_img[3];
    assign e_re  = out_re[4];
    assign e_img = out_img[4];
endmodule

// File: tb/tb_r5_input_collector.sv
// Bench for r5_input_collector: directed frames, backpressure, sof errors,
// async reset, counter wrap, then random traffic against a frame queue model.
module tb_r5_input_collector;
    import r5_pkg::*;

    logic clk, rst_n;
    logic in_valid, in_ready, in_sof, out_valid, out_ready, sof_err;
    logic [R5_DW-1:0] in_re, in_img;
    logic [R5_DW-1:0] a_re, a_img, b_re, b_img, c_re, c_img, d_re, d_img, e_re, e_img;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int consumed = 0;
    frame_t exp_q[$];
    cplx_t  part[$];

    r5_input_collector #(.DW(R5_DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_re(in_re), .in_img(in_img),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_re(a_re), .a_img(a_img), .b_re(b_re), .b_img(b_img),
        .c_re(c_re), .c_img(c_img), .d_re(d_re), .d_img(d_img),
        .e_re(e_re), .e_img(e_img),
        .sof_err(sof_err), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkf(input string tag, input frame_t obs, input frame_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic frame_t obs_f();
        frame_t f;
        f[0] = cplx_t'{re: a_re, img: a_img};
        f[1] = cplx_t'{re: b_re, img: b_img};
        f[2] = cplx_t'{re: c_re, img: c_img};
        f[3] = cplx_t'{re: d_re, img: d_img};
        f[4] = cplx_t'{re: e_re, img: e_img};
        return f;
    endfunction

    // Frame of samples base..base+4 with re=k, img=-k
    function automatic frame_t mkf(input int base);
        frame_t f;
        for (int i = 0; i < R5_POINTS; i++) begin
            f[i].re  = R5_DW'(base + i);
            f[i].img = R5_DW'(-(base + i));
        end
        return f;
    endfunction

    task automatic send(input int k, input bit sof);
        in_valid = 1'b1;
        in_sof   = sof;
        in_re    = R5_DW'(k);
        in_img   = R5_DW'(-k);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One random cycle: drive at negedge, predict handshakes, check consumed frame and sof_err.
    task automatic rcycle(input bit allow_in);
        bit v, s, ordy, acc, cons, err_exp;
        frame_t f;
        v    = allow_in && ($urandom_range(3) != 0);
        s    = ($urandom_range(11) == 0);
        ordy = allow_in ? ($urandom_range(1) == 1) : 1'b1;
        in_valid  = v;
        in_sof    = s;
        in_re     = $urandom;
        in_img    = $urandom;
        out_ready = ordy;
        acc  = v && in_ready;
        cons = out_valid && ordy;
        if (cons) begin
            if (exp_q.size() == 0)
                chk("rand_spurious_frame", 64'(exp_q.size()), 64'(1));
            else begin
                f = exp_q.pop_front();
                chkf("rand_frame", obs_f(), f);
                consumed++;
            end
        end
        err_exp = acc && s && part.size() != 0;
        if (acc) begin
            if (s) part.delete();
            part.push_back(cplx_t'{re: in_re, img: in_img});
            if (part.size() == R5_POINTS) begin
                for (int i = 0; i < R5_POINTS; i++) f[i] = part[i];
                exp_q.push_back(f);
                part.delete();
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("rand_sof_err", 64'(sof_err), 64'(err_exp));
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        in_re = '0; in_img = '0; out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chkf("reset_data", obs_f(), '0);
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_frame_cnt", 64'(frame_cnt), 64'(0));
        chk("reset_sof_err", 64'(sof_err), 64'(0));
        rst_n = 1'b1;

        // Streaming two frames with out_ready=1
        send(1, 1); send(2, 0); send(3, 0); send(4, 0);
        chk("t1_no_early_valid", 64'(out_valid), 64'(0));
        send(5, 0);
        chk("t1_f1_valid", 64'(out_valid), 64'(1));
        chkf("t1_f1_data", obs_f(), mkf(1));
        send(6, 1);
        chk("t1_valid_one_cycle", 64'(out_valid), 64'(0));
        send(7, 0); send(8, 0); send(9, 0);
        chk("t1_gap_valid", 64'(out_valid), 64'(0));
        send(10, 0);
        chk("t1_f2_valid", 64'(out_valid), 64'(1));
        chkf("t1_f2_data", obs_f(), mkf(6));
        chk("t1_frame_cnt", 64'(frame_cnt), 64'(2));
        chk("t1_sof_err", 64'(sof_err), 64'(0));
        idle(1);

        // Backpressure: one frame held, one pending
        out_ready = 1'b0;
        send(1, 1); send(2, 0); send(3, 0); send(4, 0); send(5, 0);
        chkf("t2_f1_data", obs_f(), mkf(1));
        send(6, 1); send(7, 0); send(8, 0); send(9, 0); send(10, 0);
        chk("t2_in_ready_low", 64'(in_ready), 64'(0));
        chk("t2_held_valid", 64'(out_valid), 64'(1));
        chkf("t2_held_data", obs_f(), mkf(1));
        chk("t2_cnt_held", 64'(frame_cnt), 64'(3));
        send(99, 0);
        chkf("t2_still_held", obs_f(), mkf(1));
        chk("t2_still_blocked", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        idle(1);
        chkf("t2_pend_loaded", obs_f(), mkf(6));
        chk("t2_pend_valid", 64'(out_valid), 64'(1));
        chk("t2_in_ready_back", 64'(in_ready), 64'(1));
        chk("t2_frame_cnt", 64'(frame_cnt), 64'(4));
        idle(1);
        chk("t2_drained", 64'(out_valid), 64'(0));

        // Mid-frame sof restarts the frame
        send(1, 1); send(2, 0); send(3, 0);
        send(7, 1);
        chk("t3_sof_err_pulse", 64'(sof_err), 64'(1));
        send(8, 0);
        chk("t3_sof_err_clear", 64'(sof_err), 64'(0));
        send(9, 0); send(10, 0);
        chk("t3_no_early_frame", 64'(out_valid), 64'(0));
        send(11, 0);
        chk("t3_valid", 64'(out_valid), 64'(1));
        chkf("t3_data", obs_f(), mkf(7));
        chk("t3_frame_cnt", 64'(frame_cnt), 64'(5));

        // Asynchronous reset mid-frame
        send(1, 1); send(2, 0); send(3, 0);
        #2 rst_n = 1'b0;
        #1;
        chkf("t4_async_data", obs_f(), '0);
        chk("t4_async_frame_cnt", 64'(frame_cnt), 64'(0));
        chk("t4_async_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        chk("t4_reset_valid", 64'(out_valid), 64'(0));
        rst_n = 1'b1;
        send(20, 0); send(21, 0); send(22, 0); send(23, 0); send(24, 0);
        chk("t4_valid", 64'(out_valid), 64'(1));
        chkf("t4_data", obs_f(), mkf(20));
        chk("t4_frame_cnt", 64'(frame_cnt), 64'(1));

        // Frame counter wrap from a preloaded 65535
        force dut.frame_cnt = 16'hffff;
        #1 release dut.frame_cnt;
        #1;
        chk("t6_preload", 64'(frame_cnt), 64'(16'hffff));
        send(30, 1); send(31, 0); send(32, 0); send(33, 0); send(34, 0);
        chkf("t6_data", obs_f(), mkf(30));
        chk("t6_wrap", 64'(frame_cnt), 64'(0));

        // Random traffic against the frame queue model
        do_reset();
        cyc = 0;
        while (consumed < 1000 && cyc < 40000) begin
            rcycle(1'b1);
            cyc++;
        end
        chk("rand_frames_done", 64'(consumed), 64'(1000));
        repeat (20) rcycle(1'b0);
        chk("rand_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
